// File: rtl/cl_afu_pkg.sv
// Shared definitions for the CL FIFO arbitration slice: FSM encoding, line widths
// and the watchdog counter width.
package cl_afu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StBusy  = 2'd2,
        StGuard = 2'd3
    } arb_state_e;

    localparam int unsigned ClWidth       = 512;
    localparam int unsigned ClHeadWidth   = 64;
    localparam int unsigned WdogWidth     = 12;
    localparam int unsigned GuardCntWidth = 4;

    // A grant is live (mux and request routing enabled) only in these two states.
    function automatic logic state_active(arb_state_e s);
        return (s == StGrant) || (s == StBusy);
    endfunction

endpackage

// File: rtl/cl_ff_rr_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr, with wrap.
module rr_pick
    import cl_afu_pkg::*;
#(
    parameter int unsigned NUM_FF = 4,
    parameter int unsigned W_ID   = 2
) (
    input  logic [NUM_FF-1:0] elig,
    input  logic [W_ID-1:0]   ptr,
    output logic [W_ID-1:0]   win_id,
    output logic              win_vld
);

    int unsigned      idx;
    logic [W_ID-1:0]  idx_w;

    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned i = 0; i < NUM_FF; i++) begin
            idx   = (32'(ptr) + i) % NUM_FF;
            idx_w = W_ID'(idx);
            if (!win_vld && elig[idx_w]) begin
                win_vld = 1'b1;
                win_id  = idx_w;
            end
        end
    end

endmodule

// File: rtl/cl_ff_rr_arb.sv
// Round-robin arbiter sharing one CL-to-ST converter among NUM_FF frame FIFOs.
// Whole frames only: a grant is held until the converter finishes or the watchdog fires.
module cl_ff_rr_arb
    import cl_afu_pkg::*;
#(
    parameter int unsigned NUM_FF    = 4,
    parameter int unsigned CL        = ClWidth,
    parameter int unsigned W_ID      = 2,
    parameter int unsigned GUARD_CYC = 4,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FF-1:0]    ff_en,
    input  logic [NUM_FF-1:0]    ff_rd_ready,
    output logic [NUM_FF-1:0]    ff_rdreq,
    input  logic [NUM_FF*CL-1:0] ff_q,
    output logic [NUM_FF-1:0]    ff_rd_finish,
    output logic                 cvt_rd_ready,
    input  logic                 cvt_rdreq,
    output logic [CL-1:0]        cvt_q,
    input  logic                 cvt_rd_finish,
    output logic [W_ID-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    arb_state_e                 state_q, state_d;
    logic [W_ID-1:0]            ptr_q, ptr_d;
    logic [W_ID-1:0]            grant_id_q, grant_id_d;
    logic [NUM_FF-1:0]          grant_oh_q, grant_oh_d;
    logic                       rdy_q, rdy_d;
    logic                       busy_q, busy_d;
    logic                       tmo_q, tmo_d;
    logic [NUM_FF-1:0]          fin_q, fin_d;
    logic [WdogWidth-1:0]       wdog_q, wdog_d;
    logic [GuardCntWidth-1:0]   guard_q, guard_d;

    logic [NUM_FF-1:0]          elig;
    logic [W_ID-1:0]            win_id;
    logic                       win_vld;
    logic                       active;

    // ff_en is only looked at here, so mask changes during a frame cannot disturb it.
    assign elig = ff_rd_ready & ff_en;

    rr_pick #(
        .NUM_FF (NUM_FF),
        .W_ID   (W_ID)
    ) u_rr_pick (
        .elig    (elig),
        .ptr     (ptr_q),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        rdy_d      = rdy_q;
        tmo_d      = 1'b0;
        fin_d      = '0;
        wdog_d     = wdog_q;
        guard_d    = guard_q;

        unique case (state_q)
            StIdle: begin
                guard_d = '0;
                if (win_vld) begin
                    grant_id_d = win_id;
                    grant_oh_d = NUM_FF'(1) << win_id;
                    ptr_d      = (win_id == W_ID'(NUM_FF - 1)) ? '0 : win_id + 1'b1;
                    wdog_d     = '0;
                    rdy_d      = 1'b1;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                // A finish with no preceding read request still closes the frame.
                if (cvt_rd_finish) begin
                    rdy_d   = 1'b0;
                    fin_d   = grant_oh_q;
                    state_d = StGuard;
                end else if (cvt_rdreq) begin
                    rdy_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (cvt_rd_finish) begin
                    fin_d   = grant_oh_q;
                    state_d = StGuard;
                end else if (wdog_q == WdogWidth'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                if (guard_q == GuardCntWidth'(GUARD_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = state_active(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            fin_q      <= '0;
            wdog_q     <= '0;
            guard_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            fin_q      <= fin_d;
            wdog_q     <= wdog_d;
            guard_q    <= guard_d;
        end
    end

    // Zero-latency datapath so the FIFO read latency reaches the converter unchanged.
    assign active = state_active(state_q);

    always_comb begin
        cvt_q    = '0;
        ff_rdreq = '0;
        if (active) begin
            cvt_q    = ff_q[grant_id_q*CL +: CL];
            ff_rdreq = {NUM_FF{cvt_rdreq}} & grant_oh_q;
        end
    end

    assign ff_rd_finish = fin_q;
    assign cvt_rd_ready = rdy_q;
    assign grant_id     = grant_id_q;
    assign busy         = busy_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_cl_ff_rr_arb.sv
// Bench for cl_ff_rr_arb: table of frames plus hand sequences for guard, timeout, reset.
module tb_cl_ff_rr_arb;

    localparam int unsigned NFF   = 4;
    localparam int unsigned CLW   = 512;
    localparam int unsigned WID   = 2;
    localparam int unsigned GUARD = 4;
    localparam int unsigned TMO   = 4095;

    logic               clk = 1'b0;
    logic               rst;
    logic [NFF-1:0]     ff_en;
    logic [NFF-1:0]     ff_rd_ready;
    logic [NFF-1:0]     ff_rdreq;
    logic [NFF*CLW-1:0] ff_q;
    logic [NFF-1:0]     ff_rd_finish;
    logic               cvt_rd_ready;
    logic               cvt_rdreq;
    logic [CLW-1:0]     cvt_q;
    logic               cvt_rd_finish;
    logic [WID-1:0]     grant_id;
    logic               busy;
    logic               timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];

    typedef struct {
        logic [3:0] ready;
        logic [3:0] en;
        logic [3:0] mid_en;
        int         nrd;
        int         exp_id;
    } vec_t;

    cl_ff_rr_arb #(
        .NUM_FF    (NFF),
        .CL        (CLW),
        .W_ID      (WID),
        .GUARD_CYC (GUARD),
        .TIMEOUT   (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ff_en         (ff_en),
        .ff_rd_ready   (ff_rd_ready),
        .ff_rdreq      (ff_rdreq),
        .ff_q          (ff_q),
        .ff_rd_finish  (ff_rd_finish),
        .cvt_rd_ready  (cvt_rd_ready),
        .cvt_rdreq     (cvt_rdreq),
        .cvt_q         (cvt_q),
        .cvt_rd_finish (cvt_rd_finish),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CLW-1:0] pat(input int id);
        logic [CLW-1:0] p;
        for (int w = 0; w < 16; w++) begin
            p[w*32 +: 32] = {8'(id), 8'(w), 16'hA5C3};
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [CLW-1:0] act,
                         input logic [CLW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each finish pulse must match the oldest completed frame.
    always @(negedge clk) begin
        int e;
        logic [3:0] oh;
        if (!rst && ff_rd_finish != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_finish: got %b required none", ff_rd_finish);
            end else begin
                e  = sb.pop_front();
                oh = 4'b0001 << e;
                check("finish_idx", CLW'(ff_rd_finish), CLW'(oh));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (cvt_rd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("grant_ready", CLW'(cvt_rd_ready), CLW'(1));
    endtask

    task automatic do_frame(input vec_t v);
        logic [3:0] oh;
        oh          = 4'b0001 << v.exp_id;
        ff_rd_ready = v.ready;
        ff_en       = v.en;
        wait_ready();
        check("grant_id", CLW'(grant_id), CLW'(v.exp_id));
        check("busy_grant", CLW'(busy), CLW'(1));
        check("cvt_q", cvt_q, pat(v.exp_id));
        cvt_rdreq = 1'b1;
        #1;
        check("ff_rdreq", CLW'(ff_rdreq), CLW'(oh));
        @(negedge clk);
        ff_en = v.mid_en;
        repeat (v.nrd - 1) @(negedge clk);
        check("grant_hold", CLW'(grant_id), CLW'(v.exp_id));
        check("ready_clr", CLW'(cvt_rd_ready), CLW'(0));
        cvt_rdreq = 1'b0;
        sb.push_back(v.exp_id);
        cvt_rd_finish = 1'b1;
        @(negedge clk);
        cvt_rd_finish = 1'b0;
    endtask

    initial begin
        #400_000;
        $display("FAIL global_timeout: got no end of test required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[15];
        vec_t v;
        int   n;

        vecs = '{
            '{4'b1111, 4'b1111, 4'b1111, 2, 0},
            '{4'b1111, 4'b1111, 4'b1111, 1, 1},
            '{4'b1111, 4'b1111, 4'b1111, 3, 2},
            '{4'b1111, 4'b1111, 4'b1111, 1, 3},
            '{4'b1111, 4'b1111, 4'b1111, 2, 0},
            '{4'b1111, 4'b1111, 4'b1111, 1, 1},
            '{4'b1111, 4'b1111, 4'b1111, 1, 2},
            '{4'b1111, 4'b1111, 4'b1111, 2, 3},
            '{4'b0100, 4'b1111, 4'b1111, 1, 2},
            '{4'b1111, 4'b1010, 4'b1010, 1, 3},
            '{4'b1111, 4'b1010, 4'b1010, 2, 1},
            '{4'b1111, 4'b1010, 4'b0101, 3, 3},
            '{4'b1111, 4'b0101, 4'b0101, 1, 0},
            '{4'b1001, 4'b1111, 4'b1111, 1, 3},
            '{4'b1001, 4'b1111, 4'b1111, 1, 0}
        };

        for (int i = 0; i < NFF; i++) ff_q[i*CLW +: CLW] = pat(i);
        rst           = 1'b1;
        ff_en         = '0;
        ff_rd_ready   = '0;
        cvt_rdreq     = 1'b0;
        cvt_rd_finish = 1'b0;
        #1;
        check("rst_busy", CLW'(busy), CLW'(0));
        check("rst_ready", CLW'(cvt_rd_ready), CLW'(0));
        check("rst_grant", CLW'(grant_id), CLW'(0));
        check("rst_tmo", CLW'(timeout_err), CLW'(0));
        check("rst_fin", CLW'(ff_rd_finish), CLW'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) do_frame(vecs[i]);

        // Guard window after a finish, then the earliest next grant.
        v = '{4'b0010, 4'b1111, 4'b1111, 1, 1};
        do_frame(v);
        ff_rd_ready = 4'b1111;
        check("guard_fin", CLW'(ff_rd_finish), CLW'(4'b0010));
        cvt_rdreq = 1'b1;
        for (int k = 0; k < GUARD; k++) begin
            #1;
            check("guard_ready", CLW'(cvt_rd_ready), CLW'(0));
            check("guard_rdreq", CLW'(ff_rdreq), CLW'(0));
            check("guard_cvtq", cvt_q, '0);
            check("guard_busy", CLW'(busy), CLW'(0));
            @(negedge clk);
        end
        cvt_rdreq = 1'b0;
        check("idle_ready", CLW'(cvt_rd_ready), CLW'(0));
        @(negedge clk);
        check("next_grant_ready", CLW'(cvt_rd_ready), CLW'(1));
        check("next_grant_id", CLW'(grant_id), CLW'(2));
        v = '{4'b1111, 4'b1111, 4'b1111, 1, 2};
        do_frame(v);

        // Converter never finishes: watchdog forces release.
        wait_ready();
        check("tmo_grant", CLW'(grant_id), CLW'(3));
        cvt_rdreq = 1'b1;
        @(negedge clk);
        cvt_rdreq = 1'b0;
        n = 1;
        check("tmo_busy", CLW'(busy), CLW'(1));
        while (timeout_err !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", CLW'(n), CLW'(TMO + 2));
        check("tmo_released", CLW'(busy), CLW'(0));
        @(negedge clk);
        check("tmo_pulse", CLW'(timeout_err), CLW'(0));
        v = '{4'b1111, 4'b1111, 4'b1111, 1, 0};
        do_frame(v);

        // Reset mid-frame aborts without a finish and restarts the pointer.
        wait_ready();
        check("rst_pre_grant", CLW'(grant_id), CLW'(1));
        cvt_rdreq = 1'b1;
        @(negedge clk);
        check("rst_pre_busy", CLW'(busy), CLW'(1));
        rst = 1'b1;
        #1;
        check("rstm_busy", CLW'(busy), CLW'(0));
        check("rstm_rdreq", CLW'(ff_rdreq), CLW'(0));
        check("rstm_cvtq", cvt_q, '0);
        check("rstm_grant", CLW'(grant_id), CLW'(0));
        check("rstm_ready", CLW'(cvt_rd_ready), CLW'(0));
        cvt_rdreq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        v = '{4'b1111, 4'b1111, 4'b1111, 1, 0};
        do_frame(v);

        repeat (3) @(negedge clk);
        check("sb_empty", CLW'(sb.size()), CLW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
